crtc_row_dma: RTL

Parametrised row-fetch engine for the text CRTC. Each row it copies COLS character bytes plus ATTR_PAIRS attribute byte pairs from main RAM into an on-chip row buffer, using the CPU busreq/busack handshake. It double-buffers so display reads of the current row never collide with the fetch of the next. It sits between the Z80 bus arbiter and the character generator / attribute decoder.

---
 rtl/crtc_row_dma.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/crtc_row_dma.sv
// crtc_row_dma: fetches one text row (chars + attribute pairs) from RAM into a row buffer over busreq/busack.
// Build option ROW_DMA_DOUBLE_BUF_EN: front/back banks with swap; undefined gives a single shared bank.
//
// state | meaning
// IDLE  | waiting for row_req
// REQ   | busreq raised, waiting for busack
// ADDR  | src presented on ram_adr, RAM read in flight
// DATA  | ram_data written into the fill bank at dst
// DONE  | row complete; pending swap / frame load applied
module crtc_row_dma #(
  parameter int COLS = 80,
  parameter int ATTR_PAIRS = 20,
  parameter int ADDR_W = 17,
  parameter logic [ADDR_W-1:0] BASE = 17'h0F300,
  localparam int L = COLS + 2*ATTR_PAIRS,
  localparam int RW = $clog2(L)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dma_en,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic              row_req,
  input  logic              swap,
  output logic              busreq,
  input  logic              busack,
  output logic [ADDR_W-1:0] ram_adr,
  input  logic [7:0]        ram_data,
  input  logic [RW-1:0]     rd_adr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              underrun
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, base_pend_q;
  logic [RW-1:0]     dst_q;
  logic              fs_pend_q, overrun_q, underrun_q;
  logic              busy_w, last_w, fs_apply;
  logic [7:0]        rd_byte;

  assign busy_w   = (state_q != S_IDLE);
  assign last_w   = (dst_q == RW'(L-1));
  // A frame load takes effect immediately when idle, otherwise at the end of the current row.
  assign fs_apply = ((state_q == S_IDLE) && frame_start) ||
                    ((state_q == S_DONE) && (fs_pend_q || frame_start));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (row_req && dma_en) state_d = S_REQ;
      S_REQ:   if (busack) state_d = S_ADDR;
      S_ADDR:  state_d = busack ? S_DATA : S_REQ;
      S_DATA: begin
        if (last_w)      state_d = S_DONE;
        else if (busack) state_d = S_ADDR;
        else             state_d = S_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q       <= BASE;
      base_pend_q <= BASE;
      dst_q       <= '0;
      fs_pend_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (fs_apply)                src_q <= frame_start ? base_adr : base_pend_q;
      else if (state_q == S_DATA)  src_q <= src_q + ADDR_W'(1);

      if ((state_q == S_IDLE) && row_req && dma_en) dst_q <= '0;
      else if ((state_q == S_DATA) && !last_w)      dst_q <= dst_q + RW'(1);

      if (busy_w && frame_start && (state_q != S_DONE)) begin
        fs_pend_q   <= 1'b1;
        base_pend_q <= base_adr;
      end else if (state_q == S_DONE) begin
        fs_pend_q <= 1'b0;
      end

      if (busy_w && row_req) overrun_q <= 1'b1;
      else if (fs_apply)     overrun_q <= 1'b0;
    end
  end

`ifdef ROW_DMA_DOUBLE_BUF_EN
  logic       bank_q, swap_pend_q;
  logic [7:0] mem_q [2][L];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q      <= 1'b0;
      swap_pend_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      if (((state_q == S_IDLE) && swap) ||
          ((state_q == S_DONE) && (swap_pend_q || swap)))
        bank_q <= ~bank_q;

      if (state_q == S_DONE)    swap_pend_q <= 1'b0;
      else if (busy_w && swap)  swap_pend_q <= 1'b1;

      if (busy_w && swap) underrun_q <= 1'b1;
      else if (fs_apply)  underrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_DATA) mem_q[~bank_q][dst_q] <= ram_data;
  end

  assign rd_byte = mem_q[bank_q][rd_adr];
`else
  logic       unused_swap;
  logic [7:0] mem_q [L];

  assign unused_swap = swap;
  assign underrun_q  = 1'b0;

  always_ff @(posedge clk) begin
    if (state_q == S_DATA) mem_q[dst_q] <= ram_data;
  end

  assign rd_byte = mem_q[rd_adr];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= rd_byte;
  end

  assign busreq   = busy_w;
  assign busy     = busy_w;
  assign done     = (state_q == S_DONE);
  assign ram_adr  = src_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule
